int_control_unit: RTL
=====================

// Module: int_control_unit
// PURPOSE
//  Multi-cycle sequencer directly upstream of the integer datapath. Accepts 16-bit
//  instruction words over a valid/ready handshake and decodes each one. Drives the
//  datapath controls: register addresses, alu_op, s_sel, immediate ds and write enable.
//  Latches the datapath n/z/c flags into a status register.
// PARAMETERS
//  IMM_SEXT   1   1: 5-bit immediate is sign-extended to ds[15:0]; 0: zero-extended
//  CNT_W      16  width of retire counter (used only with CU_PERF_CNT_EN)
// PORTS
//  clock      in   1      single clock; all state changes on rising edge
//  reset      in   1      synchronous, active-low; sampled on rising edge of clock
//  instr      in   16     instruction word
//  instr_vld  in   1      instr is valid
//  instr_rdy  out  1      unit accepts instr this cycle (transfer = vld & rdy)
//  we         out  1      regfile write enable to datapath
//  r_adr      out  3      datapath R read address
//  s_adr      out  3      datapath S read address
//  w_adr      out  3      datapath write address
//  alu_op     out  4      ALU operation
//  s_sel      out  1      0: S operand from regfile; 1: S operand from ds
//  ds         out  16     immediate to datapath S mux
//  n,z,c      in   1 each datapath ALU flags (combinational from datapath)
//  flags      out  3      latched {n,z,c}
//  busy       out  1      instruction in flight (state DEC/EXE/WB)
//  halted     out  1      HALT executed
//  retired    out  CNT_W  retired-instruction count (0 when feature compiled out)
// BEHAVIOUR
//  Instr format: [15:12] opcode, [11:9] rd, [8:6] rr, [5] imm, [4:2] rs, [4:0] imm5.
//  Opcode 0x0-0xD: ALU op, alu_op=opcode. 0xE: NOP. 0xF: HALT.
//  FSM states: FETCH -> DEC -> EXE -> WB -> FETCH; HALT is terminal.
//   FETCH: instr_rdy=1; on vld&rdy latch instr into IR, go to DEC; else stay.
//   DEC: drive r_adr=rr, s_adr=rs, w_adr=rd, s_sel=imm, ds=ext(imm5), alu_op.
//     Next state: NOP -> FETCH (retires); HALT -> HALT (retires); ALU op -> EXE.
//   EXE: same outputs held; on leaving EXE latch flags<={n,z,c}; go to WB.
//   WB: we=1 for exactly this cycle, same addresses/op held, so the datapath writes
//     alu_out to rd at the WB->FETCH edge; instruction retires; go to FETCH.
//   HALT: instr_rdy=0, we=0, halted=1; exits only via reset.
//  Latency: ALU instr accepted at edge T -> we high in cycle T+2 -> rd updated at edge T+3.
//   Next acceptance is possible at edge T+4 (throughput 1 instr / 4 cycles).
//  NOP/HALT consume 2 cycles (FETCH, DEC) and never assert we.
//  All control outputs are registered or decoded from IR only; no combinational
//   path from instr to any datapath control output.
//  instr_rdy is low outside FETCH; instr/instr_vld are ignored there.
//   The source must hold instr stable while vld=1 and rdy=0.
//  When s_sel=0, ds=0. When s_sel=1, s_adr still equals IR[4:2] (don't-care to datapath).
//  Reset (reset=0 at edge): state=FETCH, IR=0, we=0, alu_op=0, addresses=0, s_sel=0,
//   ds=0, flags=0, halted=0, busy=0, retired=0. instr_rdy=1 from first cycle after.
//  Reset mid-instruction (DEC/EXE/WB) aborts it with no write. A reset coinciding
//   with WB suppresses the write because we is forced 0 in the reset cycle.
//  Flags change only at EXE->WB; NOP/HALT leave flags unchanged.
// CONFIGURATION
//  CU_PERF_CNT_EN defined: retired increments by 1 on each retirement (WB, NOP,
//   HALT); wraps from 2^CNT_W-1 to 0; cleared by reset.
//  Not defined: counter logic is absent; retired is tied to 0.
// TESTING
//  Reset: hold reset=0 2 cycles -> all outputs 0, instr_rdy=1 in cycle after release.
//  Reg op: instr=0x1250 (op1, rd1, rr1, rs4), vld held 1 -> rdy 1 cycle;
//   alu_op=1, r_adr=1, s_adr=4, w_adr=1; we=1 exactly 1 cycle, 2 cycles after accept.
//  Immediate: instr=0x2A3F (op2, rd5, rr0, imm=1, imm5=0x1F) -> s_sel=1;
//   ds=0xFFFF (IMM_SEXT=1) / 0x001F (IMM_SEXT=0).
//  Flags: datapath n=1,z=0,c=1 during EXE -> flags=3'b101 from WB on; following NOP keeps 3'b101.
//  HALT: 0xF000 -> halted=1, rdy stays 0 for 20 cycles with vld=1; reset -> FETCH.
//  Abort+count: reset pulsed in EXE -> we never asserts.
//   With CU_PERF_CNT_EN, 3 ALU ops + 1 NOP -> retired=4.

Source files
------------

// File: rtl/int_control_unit.sv
// Multi-cycle FETCH/DEC/EXE/WB sequencer that drives the integer datapath controls.
// Optional retire counter is compiled in when CU_PERF_CNT_EN is defined.
module int_control_unit #(
    parameter int unsigned IMM_SEXT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             instr_vld,
    output logic             instr_rdy,
    output logic             we,
    output logic [2:0]       r_adr,
    output logic [2:0]       s_adr,
    output logic [2:0]       w_adr,
    output logic [3:0]       alu_op,
    output logic             s_sel,
    output logic [15:0]      ds,
    input  logic             n,
    input  logic             z,
    input  logic             c,
    output logic [2:0]       flags,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch,
        StDec,
        StExe,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e      state_q;
    logic [15:0] ir_q;
    logic        we_q;
    logic [2:0]  flags_q;
    logic [15:0] imm_ext;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
            we_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (instr_vld) begin
                        ir_q    <= instr;
                        state_q <= StDec;
                    end
                end
                StDec: begin
                    case (ir_q[15:12])
                        OpNop:   state_q <= StFetch;
                        OpHalt:  state_q <= StHalt;
                        default: state_q <= StExe;
                    endcase
                end
                StExe: begin
                    flags_q <= {n, z, c};
                    we_q    <= 1'b1;
                    state_q <= StWb;
                end
                StWb: begin
                    we_q    <= 1'b0;
                    state_q <= StFetch;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= StFetch;
                end
            endcase
        end
    end

    always_comb begin
        if (IMM_SEXT != 0) begin
            imm_ext = {{11{ir_q[4]}}, ir_q[4:0]};
        end else begin
            imm_ext = {11'b0, ir_q[4:0]};
        end
    end

    // Datapath controls come straight from IR, so instr never reaches them combinationally.
    assign alu_op    = ir_q[15:12];
    assign w_adr     = ir_q[11:9];
    assign r_adr     = ir_q[8:6];
    assign s_sel     = ir_q[5];
    assign s_adr     = ir_q[4:2];
    assign ds        = ir_q[5] ? imm_ext : 16'h0000;

    // Gating with reset kills a write whose WB cycle coincides with reset.
    assign we        = we_q & reset;
    assign flags     = flags_q;
    assign instr_rdy = (state_q == StFetch);
    assign busy      = (state_q == StDec) || (state_q == StExe) || (state_q == StWb);
    assign halted    = (state_q == StHalt);

`ifdef CU_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // NOP (0xE) and HALT (0xF) both retire out of DEC.
    assign retire = (state_q == StWb) || ((state_q == StDec) && (ir_q[15:13] == 3'b111));

    always_ff @(posedge clock) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule
